sdspi_cmd_engine: RTL and testbench

- Parametrised successor to the SD-over-SPI command issuer.
- Serialises a 48-bit SD command (start bits, index, argument, CRC7 computed on the fly) into the shared byte-wide SPI low-level port, then collects the card's response.
- Supports R1, R1b, R2 and R3/R7 response types, with bounded NCR and busy-wait timeouts and an explicit error code.
- Sits between the SD controller front end and the shared SPI byte engine.

---
 rtl/sdspi_cmd_engine_if.sv | 27 ++
 rtl/sdspi_cmd_engine.sv | 261 ++++++++++++++++++++++++++
 tb/tb_sdspi_cmd_engine.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sdspi_cmd_engine_if.sv
// sdspi_cmd_engine_if: command request/response and byte-wide SPI low-level signals
// shared between the SD front end, the command engine and the SPI byte engine.
interface sdspi_cmd_engine_if;
  logic        i_cmd_stb;
  logic [1:0]  i_cmd_type;
  logic [5:0]  i_cmd;
  logic [31:0] i_cmd_data;
  logic        o_busy;
  logic        o_ll_stb;
  logic [7:0]  o_ll_byte;
  logic        i_ll_busy;
  logic        i_ll_stb;
  logic [7:0]  i_ll_byte;
  logic        o_done;
  logic [1:0]  o_err;
  logic [39:0] o_response;

  modport slave (
    input  i_cmd_stb, i_cmd_type, i_cmd, i_cmd_data, i_ll_busy, i_ll_stb, i_ll_byte,
    output o_busy, o_ll_stb, o_ll_byte, o_done, o_err, o_response
  );

  modport master (
    output i_cmd_stb, i_cmd_type, i_cmd, i_cmd_data, i_ll_busy, i_ll_stb, i_ll_byte,
    input  o_busy, o_ll_stb, o_ll_byte, o_done, o_err, o_response
  );
endinterface

// File: rtl/sdspi_cmd_engine.sv
// sdspi_cmd_engine: serialises a 48-bit SD command (CRC7 on the fly) to the SPI byte port and
// collects R1/R1b/R2/R3/R7 responses. Macro SDSPI_CMD_NEC_EN adds one trailing 0xFF NEC byte.
module sdspi_cmd_engine #(
  parameter int NCR_MAX = 8,
  parameter int BUSY_TW = 24
) (
  input  logic              i_clk,
  input  logic              i_reset,
  sdspi_cmd_engine_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT_R1 = 3'd2,
    RESP    = 3'd3,
    BUSY    = 3'd4,
    NEC     = 3'd5,
    DONE    = 3'd6
  } state_t;

`ifdef SDSPI_CMD_NEC_EN
  localparam state_t FINISH = NEC;
`else
  localparam state_t FINISH = DONE;
`endif
  localparam logic [7:0]         NCR_LIM  = 8'(NCR_MAX);
  localparam logic [BUSY_TW-1:0] BUSY_LIM = {BUSY_TW{1'b1}};

  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] b);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ b[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [5:0] cmd,
                                            input logic [31:0] data, input logic [6:0] crc);
    case (idx)
      3'd0:    return {2'b01, cmd};
      3'd1:    return data[31:24];
      3'd2:    return data[23:16];
      3'd3:    return data[15:8];
      3'd4:    return data[7:0];
      3'd5:    return {crc, 1'b1};
      default: return 8'hff;
    endcase
  endfunction

  state_t              state_r, state_s;
  logic                pending_r, pending_s;
  logic [1:0]          type_r, type_s;
  logic [5:0]          cmd_r, cmd_s;
  logic [31:0]         data_r, data_s;
  logic [6:0]          crc_r, crc_s;
  logic [2:0]          idx_r, idx_s;
  logic [7:0]          fill_r, fill_s;
  logic [2:0]          remain_r, remain_s;
  logic [BUSY_TW-1:0]  bcnt_r, bcnt_s;
  logic                busy_r, busy_s;
  logic                ll_stb_r, ll_stb_s;
  logic [7:0]          ll_byte_r, ll_byte_s;
  logic                done_r, done_s;
  logic [1:0]          err_r, err_s;
  logic [39:0]         resp_r, resp_s;
  logic                accept_s, rx_s;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_s   = state_r;
    type_s    = type_r;
    cmd_s     = cmd_r;
    data_s    = data_r;
    crc_s     = crc_r;
    idx_s     = idx_r;
    fill_s    = fill_r;
    remain_s  = remain_r;
    bcnt_s    = bcnt_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    err_s     = err_r;
    resp_s    = resp_r;
    accept_s  = ll_stb_r && !bus.i_ll_busy;
    rx_s      = pending_r && bus.i_ll_stb;

    // Only one byte may be outstanding; stray receive strobes are ignored.
    if (accept_s) begin
      pending_s = 1'b1;
    end else if (rx_s) begin
      pending_s = 1'b0;
    end else begin
      pending_s = pending_r;
    end

    case (state_r)
      IDLE: begin
        if (bus.i_cmd_stb) begin
          state_s  = SEND;
          busy_s   = 1'b1;
          type_s   = bus.i_cmd_type;
          cmd_s    = bus.i_cmd;
          data_s   = bus.i_cmd_data;
          crc_s    = 7'd0;
          idx_s    = 3'd0;
          fill_s   = 8'd0;
          remain_s = 3'd0;
          bcnt_s   = '0;
          err_s    = 2'b00;
          resp_s   = 40'd0;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (accept_s) begin
          if (idx_r < 3'd5) begin
            crc_s = crc7_byte(crc_r, ll_byte_r);
          end else begin
            crc_s = crc_r;
          end
          idx_s = idx_r + 3'd1;
        end else if (rx_s && (idx_r == 3'd6)) begin
          state_s = WAIT_R1;
          fill_s  = 8'd0;
        end else begin
          state_s = SEND;
        end
      end
      WAIT_R1: begin
        if (rx_s && !bus.i_ll_byte[7]) begin
          resp_s = {32'd0, bus.i_ll_byte};
          case (type_r)
            2'b00: state_s = FINISH;
            2'b01: state_s = BUSY;
            2'b10: begin
              state_s  = RESP;
              remain_s = 3'd1;
            end
            2'b11: begin
              state_s  = RESP;
              remain_s = 3'd4;
            end
            default: state_s = FINISH;
          endcase
        end else if (rx_s) begin
          fill_s = fill_r + 8'd1;
          if (fill_s == NCR_LIM) begin
            err_s   = 2'b01;
            state_s = FINISH;
          end else begin
            state_s = WAIT_R1;
          end
        end else begin
          state_s = WAIT_R1;
        end
      end
      RESP: begin
        if (rx_s) begin
          resp_s   = {resp_r[31:0], bus.i_ll_byte};
          remain_s = remain_r - 3'd1;
          if (remain_r == 3'd1) begin
            state_s = FINISH;
          end else begin
            state_s = RESP;
          end
        end else begin
          state_s = RESP;
        end
      end
      BUSY: begin
        if (rx_s && (bus.i_ll_byte != 8'h00)) begin
          state_s = FINISH;
        end else if (rx_s) begin
          bcnt_s = bcnt_r + {{(BUSY_TW-1){1'b0}}, 1'b1};
          if (bcnt_s == BUSY_LIM) begin
            err_s   = 2'b10;
            state_s = FINISH;
          end else begin
            state_s = BUSY;
          end
        end else begin
          state_s = BUSY;
        end
      end
      NEC: begin
        if (rx_s) begin
          state_s = DONE;
        end else begin
          state_s = NEC;
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b1;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase

    ll_stb_s = busy_s && !pending_s && (state_s != DONE);
    if (state_s == SEND) begin
      ll_byte_s = frame_byte(idx_s, cmd_s, data_s, crc_s);
    end else begin
      ll_byte_s = 8'hff;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r   <= IDLE;
      pending_r <= 1'b0;
      type_r    <= 2'b00;
      cmd_r     <= 6'd0;
      data_r    <= 32'd0;
      crc_r     <= 7'd0;
      idx_r     <= 3'd0;
      fill_r    <= 8'd0;
      remain_r  <= 3'd0;
      bcnt_r    <= '0;
      busy_r    <= 1'b0;
      ll_stb_r  <= 1'b0;
      ll_byte_r <= 8'hff;
      done_r    <= 1'b0;
      err_r     <= 2'b00;
      resp_r    <= 40'd0;
    end else begin
      state_r   <= state_s;
      pending_r <= pending_s;
      type_r    <= type_s;
      cmd_r     <= cmd_s;
      data_r    <= data_s;
      crc_r     <= crc_s;
      idx_r     <= idx_s;
      fill_r    <= fill_s;
      remain_r  <= remain_s;
      bcnt_r    <= bcnt_s;
      busy_r    <= busy_s;
      ll_stb_r  <= ll_stb_s;
      ll_byte_r <= ll_byte_s;
      done_r    <= done_s;
      err_r     <= err_s;
      resp_r    <= resp_s;
    end
  end

  assign bus.o_busy     = busy_r;
  assign bus.o_ll_stb   = ll_stb_r;
  assign bus.o_ll_byte  = ll_byte_r;
  assign bus.o_done     = done_r;
  assign bus.o_err      = err_r;
  assign bus.o_response = resp_r;

endmodule

// File: tb/tb_sdspi_cmd_engine.sv
// Directed bench for sdspi_cmd_engine: acts as SPI byte engine and SD card, checks frames,
// responses, NCR/busy timeouts, the one-outstanding rule and reset abort.
module tb_sdspi_cmd_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;
  int   viol_count = 0;
  logic tb_pend;
  bit   rand_busy = 1'b0;

  sdspi_cmd_engine_if bus();

  sdspi_cmd_engine #(.NCR_MAX(8), .BUSY_TW(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Outstanding-byte tracker of the SPI side.
  always @(posedge clk) begin
    if (rst) tb_pend <= 1'b0;
    else if (bus.o_ll_stb && !bus.i_ll_busy) tb_pend <= 1'b1;
    else if (bus.i_ll_stb) tb_pend <= 1'b0;
  end

  // Done-pulse counter and strobe-while-pending detector.
  always @(negedge clk) begin
    if (bus.o_done) done_count <= done_count + 1;
    if (bus.o_ll_stb && tb_pend) viol_count <= viol_count + 1;
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] t, input logic [5:0] c, input logic [31:0] d);
    @(negedge clk);
    bus.i_cmd_stb  = 1'b1;
    bus.i_cmd_type = t;
    bus.i_cmd      = c;
    bus.i_cmd_data = d;
    @(negedge clk);
    bus.i_cmd_stb  = 1'b0;
  endtask

  // One SPI byte transfer: wait for the engine's byte, then return miso.
  task automatic xfer(input logic [7:0] miso, output logic [7:0] mosi);
    bit got;
    got  = 1'b0;
    mosi = 8'h00;
    for (int n = 0; n < 200; n++) begin
      bus.i_ll_busy = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (bus.o_ll_stb && !bus.i_ll_busy) begin
        got  = 1'b1;
        mosi = bus.o_ll_byte;
        break;
      end
      @(negedge clk);
    end
    check("xfer_accept", 40'(got), 40'd1);
    if (got) begin
      @(negedge clk);
      bus.i_ll_busy = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.i_ll_stb  = 1'b1;
      bus.i_ll_byte = miso;
      @(negedge clk);
      bus.i_ll_stb  = 1'b0;
    end
  endtask

  task automatic send_frame(input string tag, input logic [47:0] frame, input bit inject);
    logic [7:0] m;
    for (int i = 0; i < 6; i++) begin
      xfer(8'hff, m);
      check(tag, 40'(m), 40'(frame[47-8*i -: 8]));
      if (inject && (i == 1)) begin
        bus.i_ll_busy = 1'b1;
        issue(2'b00, 6'd17, 32'hdead_beef);
      end
    end
  endtask

  task automatic wait_done(input string tag, input logic [1:0] exp_err,
                           input logic [39:0] exp_resp, input int exp_count);
    bit seen;
    logic [7:0] m;
    seen = 1'b0;
`ifdef SDSPI_CMD_NEC_EN
    xfer(8'hff, m);
    check({tag, "_nec"}, 40'(m), 40'hff);
`endif
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.o_done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, 40'(seen), 40'd1);
    check({tag, "_err"}, 40'(bus.o_err), 40'(exp_err));
    check({tag, "_resp"}, bus.o_response, exp_resp);
    check({tag, "_busy"}, 40'(bus.o_busy), 40'd0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_count"}, 40'(done_count), 40'(exp_count));
  endtask

  initial begin
    logic [7:0] m;
    bus.i_cmd_stb  = 1'b0;
    bus.i_cmd_type = 2'b00;
    bus.i_cmd      = 6'd0;
    bus.i_cmd_data = 32'd0;
    bus.i_ll_busy  = 1'b0;
    bus.i_ll_stb   = 1'b0;
    bus.i_ll_byte  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", 40'(bus.o_busy), 40'd0);
    check("rst_ll_stb", 40'(bus.o_ll_stb), 40'd0);
    check("rst_ll_byte", 40'(bus.o_ll_byte), 40'hff);
    check("rst_done", 40'(bus.o_done), 40'd0);
    check("rst_err", 40'(bus.o_err), 40'd0);
    check("rst_resp", bus.o_response, 40'd0);
    rst = 1'b0;
    @(negedge clk);

    // CMD0, R1: one fill byte then 0x01.
    issue(2'b00, 6'd0, 32'h0);
    send_frame("cmd0_tx", 48'h40_00000000_95, 1'b0);
    xfer(8'hff, m);
    check("cmd0_fill", 40'(m), 40'hff);
    xfer(8'h01, m);
    check("cmd0_r1", 40'(m), 40'hff);
    wait_done("cmd0", 2'b00, 40'h01, 1);

    // CMD8, R7, with a command strobe injected mid-frame that must be ignored.
    issue(2'b11, 6'd8, 32'h0000_01aa);
    send_frame("cmd8_tx", 48'h48_000001aa_87, 1'b1);
    xfer(8'h01, m);
    xfer(8'h00, m);
    xfer(8'h00, m);
    xfer(8'h01, m);
    xfer(8'haa, m);
    wait_done("cmd8", 2'b00, 40'h01_0000_01aa, 2);

    // CMD13, R2, with i_ll_busy randomly toggled.
    rand_busy = 1'b1;
    issue(2'b10, 6'd13, 32'h0);
    send_frame("cmd13_tx", 48'h4d_00000000_0d, 1'b0);
    xfer(8'hff, m);
    xfer(8'h00, m);
    xfer(8'h00, m);
    rand_busy = 1'b0;
    bus.i_ll_busy = 1'b0;
    wait_done("cmd13", 2'b00, 40'h0, 3);
    check("no_stb_while_pending", 40'(viol_count), 40'd0);

    // CMD0 with no card response: exactly 8 fill bytes then NCR error.
    issue(2'b00, 6'd0, 32'h0);
    send_frame("ncr_tx", 48'h40_00000000_95, 1'b0);
    for (int i = 0; i < 8; i++) xfer(8'hff, m);
    wait_done("ncr", 2'b01, 40'h0, 4);

    // CMD12, R1b: response 00, three busy zeros, then release.
    issue(2'b01, 6'd12, 32'h0);
    send_frame("r1b_tx", 48'h4c_00000000_61, 1'b0);
    xfer(8'h00, m);
    for (int i = 0; i < 3; i++) xfer(8'h00, m);
    xfer(8'hff, m);
    wait_done("r1b", 2'b00, 40'h0, 5);

    // CMD12, R1b, card stays busy: timeout after 15 zero busy bytes.
    issue(2'b01, 6'd12, 32'h0);
    send_frame("btmo_tx", 48'h4c_00000000_61, 1'b0);
    xfer(8'h00, m);
    for (int i = 0; i < 15; i++) xfer(8'h00, m);
    wait_done("btmo", 2'b10, 40'h0, 6);

    // Reset mid-SEND after byte 2, then a clean CMD0.
    issue(2'b00, 6'd0, 32'h0);
    xfer(8'hff, m);
    check("abort_b0", 40'(m), 40'h40);
    xfer(8'hff, m);
    check("abort_b1", 40'(m), 40'h00);
    bus.i_ll_busy = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy", 40'(bus.o_busy), 40'd0);
    check("abort_ll_stb", 40'(bus.o_ll_stb), 40'd0);
    check("abort_ll_byte", 40'(bus.o_ll_byte), 40'hff);
    rst = 1'b0;
    bus.i_ll_busy = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_done", 40'(done_count), 40'd6);
    issue(2'b00, 6'd0, 32'h0);
    send_frame("post_rst_tx", 48'h40_00000000_95, 1'b0);
    xfer(8'h01, m);
    wait_done("post_rst", 2'b00, 40'h01, 7);
    check("final_no_stb_while_pending", 40'(viol_count), 40'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
